// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Circular FIFO between the instruction fetcher and the dispatcher. Holds
// fetched instructions together with their PC and hands at most one per cycle
// to the dispatcher, and only when both the reservation station and the
// reorder buffer have room. A reorder-buffer misprediction flush empties it.
//
// Ports
//   clk_in                  clock, all state updates on the rising edge
//   rst_in                  asynchronous active-low reset
//   rdy_in                  global enable, low freezes every register
//   if_iq_en_in             fetcher pushes one entry this cycle
//   if_iq_inst_in           instruction word to push
//   if_iq_pc_in             PC of the pushed instruction
//   iq_if_rdy_out           queue not full (combinational from count)
//   rs_iq_rdy_in            reservation station has a free entry
//   rob_iq_rdy_in           reorder buffer has a free entry
//   iq_dispatcher_en_out    registered one-cycle valid pulse to dispatcher
//   iq_dispatcher_inst_out  registered instruction word
//   iq_dispatcher_pc_out    registered PC
//   rob_iq_rst_in           synchronous flush on misprediction, active-high
//   iq_count_out            current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module inst_queue #(
  parameter int IQ_WIDTH   = 4,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  if_iq_en_in,
  input  logic [INST_WIDTH-1:0] if_iq_inst_in,
  input  logic [ADDR_WIDTH-1:0] if_iq_pc_in,
  output logic                  iq_if_rdy_out,
  input  logic                  rs_iq_rdy_in,
  input  logic                  rob_iq_rdy_in,
  output logic                  iq_dispatcher_en_out,
  output logic [INST_WIDTH-1:0] iq_dispatcher_inst_out,
  output logic [ADDR_WIDTH-1:0] iq_dispatcher_pc_out,
  input  logic                  rob_iq_rst_in,
  output logic [IQ_WIDTH:0]     iq_count_out
);

  localparam int                DEPTH    = 2 ** IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] FULL_CNT = (IQ_WIDTH + 1)'(DEPTH);
  localparam logic [IQ_WIDTH:0] CNT_ONE  = (IQ_WIDTH + 1)'(1);
  localparam logic [IQ_WIDTH-1:0] PTR_ONE = IQ_WIDTH'(1);

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];

  logic [IQ_WIDTH-1:0] head;
  logic [IQ_WIDTH-1:0] tail;
  logic [IQ_WIDTH:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Both full and push use the occupancy at the start of the cycle, so a pop
  // in the same cycle does not open a slot for a push into a full queue.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = if_iq_en_in && !full;
  assign pop   = !empty && rs_iq_rdy_in && rob_iq_rdy_in;

  assign iq_if_rdy_out = !full;
  assign iq_count_out  = count;

  // Entry storage: no reset, only slots between head and tail are ever read.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !rob_iq_rst_in && push) begin
      inst_mem[tail] <= if_iq_inst_in;
      pc_mem[tail]   <= if_iq_pc_in;
    end
  end

  // Pointer/count bookkeeping and the registered dispatch stage.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head                   <= '0;
      tail                   <= '0;
      count                  <= '0;
      iq_dispatcher_en_out   <= 1'b0;
      iq_dispatcher_inst_out <= '0;
      iq_dispatcher_pc_out   <= '0;
    end else if (rdy_in) begin
      if (rob_iq_rst_in) begin
        head                 <= '0;
        tail                 <= '0;
        count                <= '0;
        iq_dispatcher_en_out <= 1'b0;
      end else begin
        if (push) begin
          tail <= tail + PTR_ONE;
        end
        if (pop) begin
          head                   <= head + PTR_ONE;
          iq_dispatcher_inst_out <= inst_mem[head];
          iq_dispatcher_pc_out   <= pc_mem[head];
        end
        iq_dispatcher_en_out <= pop;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        if_iq_en_in = 1'b0;
  logic [31:0] if_iq_inst_in = '0;
  logic [31:0] if_iq_pc_in = '0;
  logic        iq_if_rdy_out;
  logic        rs_iq_rdy_in = 1'b0;
  logic        rob_iq_rdy_in = 1'b0;
  logic        iq_dispatcher_en_out;
  logic [31:0] iq_dispatcher_inst_out;
  logic [31:0] iq_dispatcher_pc_out;
  logic        rob_iq_rst_in = 1'b0;
  logic [4:0]  iq_count_out;

  always #5 clk_in = ~clk_in;

  inst_queue #(.IQ_WIDTH(4), .INST_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    .if_iq_en_in            (if_iq_en_in),
    .if_iq_inst_in          (if_iq_inst_in),
    .if_iq_pc_in            (if_iq_pc_in),
    .iq_if_rdy_out          (iq_if_rdy_out),
    .rs_iq_rdy_in           (rs_iq_rdy_in),
    .rob_iq_rdy_in          (rob_iq_rdy_in),
    .iq_dispatcher_en_out   (iq_dispatcher_en_out),
    .iq_dispatcher_inst_out (iq_dispatcher_inst_out),
    .iq_dispatcher_pc_out   (iq_dispatcher_pc_out),
    .rob_iq_rst_in          (rob_iq_rst_in),
    .iq_count_out           (iq_count_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural reference: an ordered list of queued entries plus the value
  // the dispatch registers should hold.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic        exp_en   = 1'b0;
  logic [31:0] exp_pc   = '0;
  logic [31:0] exp_inst = '0;

  typedef struct {
    logic        en;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rs;
    logic        rob;
    logic        x_en;
    logic [31:0] x_pc;
    logic [31:0] x_inst;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t tv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hA5A5, pc[15:0]};
  endfunction

  task automatic cycle(input logic en, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rs, input logic rob, input logic fl, input logic rdy);
    if_iq_en_in   = en;
    if_iq_pc_in   = pc;
    if_iq_inst_in = inst;
    rs_iq_rdy_in  = rs;
    rob_iq_rdy_in = rob;
    rob_iq_rst_in = fl;
    rdy_in        = rdy;
    @(posedge clk_in);
    #1;
  endtask

  task automatic step(input string tag, input logic en, input logic [31:0] pc,
                      input logic rs, input logic rob, input logic fl, input logic rdy);
    bit full, pop, push;
    cycle(en, pc, inst_of(pc), rs, rob, fl, rdy);
    if (rdy) begin
      if (fl) begin
        mq_pc.delete();
        mq_inst.delete();
        exp_en = 1'b0;
      end else begin
        full = (mq_pc.size() == 16);
        pop  = (mq_pc.size() != 0) && rs && rob;
        push = en && !full;
        exp_en = pop;
        if (pop) begin
          exp_pc   = mq_pc.pop_front();
          exp_inst = mq_inst.pop_front();
        end
        if (push) begin
          mq_pc.push_back(pc);
          mq_inst.push_back(inst_of(pc));
        end
      end
    end
    check({tag, " en"},    32'(iq_dispatcher_en_out), 32'(exp_en));
    check({tag, " count"}, 32'(iq_count_out), 32'(mq_pc.size()));
    check({tag, " rdy"},   32'(iq_if_rdy_out), 32'(mq_pc.size() != 16));
    check({tag, " pc"},    iq_dispatcher_pc_out, exp_pc);
    check({tag, " inst"},  iq_dispatcher_inst_out, exp_inst);
  endtask

  // Reset is asserted between clock edges and must take effect at once.
  task automatic do_reset(input string tag);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    check({tag, " count"}, 32'(iq_count_out), 32'd0);
    check({tag, " en"},    32'(iq_dispatcher_en_out), 32'd0);
    check({tag, " rdy"},   32'(iq_if_rdy_out), 32'd1);
    check({tag, " pc"},    iq_dispatcher_pc_out, 32'd0);
    check({tag, " inst"},  iq_dispatcher_inst_out, 32'd0);
    if_iq_en_in = 1'b0; rs_iq_rdy_in = 1'b0; rob_iq_rdy_in = 1'b0;
    rob_iq_rst_in = 1'b0; rdy_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b1;
    mq_pc.delete();
    mq_inst.delete();
    exp_en = 1'b0; exp_pc = '0; exp_inst = '0;
  endtask

  initial begin
    logic [31:0] pc_n;
    logic [31:0] last_pc;
    int          n_disp;
    int          guard;

    // Table for the basic three-instruction stream with both consumers ready.
    tv[0] = '{1'b1, 32'h0, 32'h13, 1'b1, 1'b1, 1'b0, 32'h0, 32'h00, 32'd1};
    tv[1] = '{1'b1, 32'h4, 32'h13, 1'b1, 1'b1, 1'b1, 32'h0, 32'h13, 32'd1};
    tv[2] = '{1'b1, 32'h8, 32'h13, 1'b1, 1'b1, 1'b1, 32'h4, 32'h13, 32'd1};
    tv[3] = '{1'b0, 32'h0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h8, 32'h13, 32'd0};
    tv[4] = '{1'b0, 32'h0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h8, 32'h13, 32'd0};

    do_reset("init");

    // Reset asserted mid-stream with five entries queued and a pulse live.
    for (int i = 0; i < 6; i++) step("t1 fill", 1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    step("t1 pop", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t1 pre count", 32'(iq_count_out), 32'd5);
    check("t1 pre en", 32'(iq_dispatcher_en_out), 32'd1);
    do_reset("t1 rst");

    // Table-driven stream.
    for (int i = 0; i < 5; i++) begin
      cycle(tv[i].en, tv[i].pc, tv[i].inst, tv[i].rs, tv[i].rob, 1'b0, 1'b1);
      check($sformatf("t2 v%0d en", i),    32'(iq_dispatcher_en_out), 32'(tv[i].x_en));
      check($sformatf("t2 v%0d pc", i),    iq_dispatcher_pc_out, tv[i].x_pc);
      check($sformatf("t2 v%0d inst", i),  iq_dispatcher_inst_out, tv[i].x_inst);
      check($sformatf("t2 v%0d count", i), 32'(iq_count_out), tv[i].x_cnt);
    end

    // Fill to capacity, 17th push dropped, then drain in order.
    do_reset("t3 rst");
    for (int i = 0; i < 16; i++) step("t3 fill", 1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3 full count", 32'(iq_count_out), 32'd16);
    check("t3 full rdy", 32'(iq_if_rdy_out), 32'd0);
    step("t3 drop", 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3 drop count", 32'(iq_count_out), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step("t3 drain", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t3 drain pc%0d", i), iq_dispatcher_pc_out, 32'h100 + 32'(4 * i));
    end
    step("t3 empty", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3 last pc", iq_dispatcher_pc_out, 32'h13C);
    check("t3 end en", 32'(iq_dispatcher_en_out), 32'd0);

    // Fill with ROB readiness toggling, then stream across two wraps.
    do_reset("t4 rst");
    pc_n = 32'h1000;
    last_pc = 32'h1000 - 32'd4;
    guard = 0;
    while (mq_pc.size() != 16 && guard < 200) begin
      step("t4 fill", mq_pc.size() != 16, pc_n, 1'b1, guard[0], 1'b0, 1'b1);
      pc_n += 32'd4;
      if (iq_dispatcher_en_out) begin
        check("t4 fill order", iq_dispatcher_pc_out, last_pc + 32'd4);
        last_pc = iq_dispatcher_pc_out;
      end
      guard++;
    end
    check("t4 fill reached", 32'(mq_pc.size()), 32'd16);
    n_disp = 0;
    for (int i = 0; i < 40; i++) begin
      if (mq_pc.size() != 16) begin
        step("t4 stream", 1'b1, pc_n, 1'b1, 1'b1, 1'b0, 1'b1);
        pc_n += 32'd4;
      end else begin
        step("t4 stream", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      end
      if (iq_dispatcher_en_out) begin
        check("t4 order", iq_dispatcher_pc_out, last_pc + 32'd4);
        last_pc = iq_dispatcher_pc_out;
        n_disp++;
      end
    end
    check("t4 pops", 32'(n_disp), 32'd40);

    // Flush with a concurrent push.
    do_reset("t5 rst");
    for (int i = 0; i < 7; i++) step("t5 fill", 1'b1, 32'h2000 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    check("t5 pre count", 32'(iq_count_out), 32'd7);
    step("t5 flush", 1'b1, 32'h3000, 1'b1, 1'b1, 1'b1, 1'b1);
    check("t5 flush count", 32'(iq_count_out), 32'd0);
    check("t5 flush en", 32'(iq_dispatcher_en_out), 32'd0);
    for (int i = 0; i < 3; i++) step("t5 idle", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t5 push", 1'b1, 32'h3004, 1'b1, 1'b1, 1'b0, 1'b1);
    step("t5 pop", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t5 new en", 32'(iq_dispatcher_en_out), 32'd1);
    check("t5 new pc", iq_dispatcher_pc_out, 32'h3004);

    // Global freeze with a live pulse and four queued entries.
    do_reset("t6 rst");
    for (int i = 0; i < 5; i++) step("t6 fill", 1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    step("t6 pop", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("t6 frz", 1'b1, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0);
      check("t6 frz count", 32'(iq_count_out), 32'd4);
      check("t6 frz en", 32'(iq_dispatcher_en_out), 32'd1);
      check("t6 frz pc", iq_dispatcher_pc_out, 32'h4000);
    end
    for (int i = 0; i < 4; i++) begin
      step("t6 resume", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      check($sformatf("t6 resume pc%0d", i), iq_dispatcher_pc_out, 32'h4004 + 32'(4 * i));
    end
    step("t6 done", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t6 done en", 32'(iq_dispatcher_en_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
